// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter slice: opcodes, FSM states, datapath width.
// Imported by the interface, arbiter, ALU core and top.
package alu_pkg;

   localparam int ALU_W = 8;

   typedef enum logic [2:0] {
      ADD = 3'b000,
      AND = 3'b001,
      SUB = 3'b010,
      OR  = 3'b011,
      XOR = 3'b100,
      MUL = 3'b101,
      DIV = 3'b110,
      MIN = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters and alu_arbiter.
// master: requester side (drives req_*, rsp_ready); slave: the arbiter.
interface alu_arbiter_if
   import alu_pkg::*;
#(
   parameter int N    = ALU_W,
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
);

   logic [NREQ-1:0]         req_valid;
   logic [NREQ-1:0]         req_ready;
   logic [NREQ-1:0][2:0]    req_op;
   logic [NREQ-1:0][N-1:0]  req_a;
   logic [NREQ-1:0][N-1:0]  req_b;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [IDW-1:0]          rsp_id;
   logic [2*N-1:0]          rsp_data;
   logic                    rsp_dbz;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_dbz
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_dbz
   );

endinterface

// File: rtl/alu_core.sv
// Combinational unsigned ALU; result zero-extended to 2N bits.
// Ports: op, a, b in; y out (full product for MUL, quotient for DIV).
module alu_core
   import alu_pkg::*;
#(
   parameter int N = ALU_W
) (
   input  alu_op_e        op,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] y
);

   logic [2*N-1:0] ax, bx;
   logic [N-1:0]   diff, quo;

   always_comb begin
      ax   = {{N{1'b0}}, a};
      bx   = {{N{1'b0}}, b};
      diff = a - b;
      quo  = a / b;
      y    = '0;
      unique case (op)
         ADD: y = ax + bx;
         AND: y = ax & bx;
         SUB: y = {{N{1'b0}}, diff};
         OR:  y = ax | bx;
         XOR: y = ax ^ bx;
         MUL: y = ax * bx;
         DIV: y = {{N{1'b0}}, quo};
         MIN: y = (a < b) ? ax : bx;
      endcase
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
// Ports: req (request vector), ptr (search start), gnt_v / gnt_idx (winner).
module rr_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            gnt_v,
   output logic [IDW-1:0]  gnt_idx
);

   logic [IDW-1:0] idx;

   always_comb begin
      gnt_v   = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = IDW'((int'(ptr) + i) % NREQ);
         if (!gnt_v && req[idx]) begin
            gnt_v   = 1'b1;
            gnt_idx = idx;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between NREQ requesters, registered held response.
// Ports: clk, rst_n, bus (alu_arbiter_if.slave). Option: ALU_DIV_GUARD_EN.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int N    = ALU_W,
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_arbiter_if.slave bus
);

   arb_state_e     state, nstate;
   logic [IDW-1:0] ptr, gnt_idx, id_q;
   logic           gnt_v, grant;
   alu_op_e        op_q;
   logic [N-1:0]   a_q, b_q;
   logic [2*N-1:0] alu_y, res;
   logic           dbz;
   logic           rsp_valid_q, rsp_dbz_q;
   logic [IDW-1:0] rsp_id_q;
   logic [2*N-1:0] rsp_data_q;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
      .req     (bus.req_valid),
      .ptr     (ptr),
      .gnt_v   (gnt_v),
      .gnt_idx (gnt_idx)
   );

   alu_core #(.N(N)) u_alu (
      .op (op_q),
      .a  (a_q),
      .b  (b_q),
      .y  (alu_y)
   );

`ifdef ALU_DIV_GUARD_EN
   assign dbz = (op_q == DIV) && (b_q == '0);
   assign res = dbz ? '1 : alu_y;
`else
   assign dbz = 1'b0;
   assign res = alu_y;
`endif

   // A grant happens from IDLE, or from RESP in the cycle the
   // response is consumed, so back-to-back ops take 2 cycles.
   always_comb begin
      nstate = state;
      grant  = 1'b0;
      unique case (state)
         IDLE: grant = gnt_v;
         EXEC: nstate = RESP;
         RESP: begin
            if (bus.rsp_ready) begin
               grant  = gnt_v;
               nstate = IDLE;
            end
         end
         default: nstate = IDLE;
      endcase
      if (grant) nstate = EXEC;
   end

   always_comb begin
      bus.req_ready = '0;
      for (int i = 0; i < NREQ; i++)
         bus.req_ready[i] = rst_n && grant && (gnt_idx == IDW'(i));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr         <= '0;
         op_q        <= ADD;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         rsp_dbz_q   <= 1'b0;
      end else begin
         if (grant) begin
            op_q <= alu_op_e'(bus.req_op[gnt_idx]);
            a_q  <= bus.req_a[gnt_idx];
            b_q  <= bus.req_b[gnt_idx];
            id_q <= gnt_idx;
            ptr  <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
         end
         if (state == EXEC) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= res;
            rsp_id_q    <= id_q;
            rsp_dbz_q   <= dbz;
         end else if (state == RESP && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_dbz   = rsp_dbz_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, latency, rotation, stall, div, min, abort.
// Guarded-divide vectors run only when ALU_DIV_GUARD_EN is defined.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int N    = 8;
   localparam int NREQ = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   passed = 0;
   int   fails  = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   alu_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

   alu_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rsp_chk(input string tag, input logic [15:0] d,
                          input logic id, input logic z);
      chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, "_data"},  32'(bus.rsp_data),  32'(d));
      chk({tag, "_id"},    32'(bus.rsp_id),    32'(id));
      chk({tag, "_dbz"},   32'(bus.rsp_dbz),   32'(z));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setreq(input int r, input alu_op_e op,
                         input logic [7:0] a, input logic [7:0] b);
      bus.req_op[r] = op;
      bus.req_a[r]  = a;
      bus.req_b[r]  = b;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      setreq(0, ADD, 8'hF0, 8'h20);
      bus.req_valid = 2'b01;
      step();
      step();
      chk("rst_valid", 32'(bus.rsp_valid), 0);
      chk("rst_data",  32'(bus.rsp_data),  0);
      chk("rst_id",    32'(bus.rsp_id),    0);
      chk("rst_dbz",   32'(bus.rsp_dbz),   0);
      chk("rst_ready", 32'(bus.req_ready), 0);

      // single add from requester 0
      rst_n         = 1'b1;
      bus.rsp_ready = 1'b1;
      #1;
      chk("add_ready", 32'(bus.req_ready), 32'b01);
      step();
      bus.req_valid = '0;
      chk("add_exec_ready", 32'(bus.req_ready), 0);
      chk("add_lat", 32'(bus.rsp_valid), 0);
      step();
      rsp_chk("add", 16'h0110, 1'b0, 1'b0);
      step();
      chk("add_idle", 32'(bus.rsp_valid), 0);

      // min from requester 1 (pointer now 1)
      setreq(1, MIN, 8'h09, 8'h04);
      bus.req_valid = 2'b10;
      #1;
      chk("min_ready", 32'(bus.req_ready), 32'b10);
      step();
      bus.req_valid = '0;
      step();
      rsp_chk("min_a", 16'h0004, 1'b1, 1'b0);
      step();

      // contention: pointer back at 0
      setreq(0, MUL, 8'hFF, 8'hFF);
      setreq(1, SUB, 8'h05, 8'h07);
      bus.req_valid = 2'b11;
      #1;
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("rot%0d_ready", g), 32'(bus.req_ready),
             (g % 2 == 1) ? 32'b10 : 32'b01);
         step();
         step();
         rsp_chk($sformatf("rot%0d", g),
                 (g % 2 == 1) ? 16'h00FE : 16'hFE01,
                 (g % 2 == 1), 1'b0);
      end

      // backpressure with requester 1 pending
      bus.rsp_ready = 1'b0;
      bus.req_valid = 2'b10;
      setreq(1, XOR, 8'h3C, 8'h0F);
      #1;
      chk("bp_ready0", 32'(bus.req_ready), 0);
      for (int c = 0; c < 5; c++) begin
         step();
         chk($sformatf("bp%0d_valid", c), 32'(bus.rsp_valid), 1);
         chk($sformatf("bp%0d_data", c),  32'(bus.rsp_data),  32'h00FE);
         chk($sformatf("bp%0d_id", c),    32'(bus.rsp_id),    1);
         chk($sformatf("bp%0d_ready", c), 32'(bus.req_ready), 0);
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp_grant", 32'(bus.req_ready), 32'b10);
      step();
      bus.req_valid = '0;
      chk("bp_exec", 32'(bus.rsp_valid), 0);
      step();
      rsp_chk("xor", 16'h0033, 1'b1, 1'b0);
      step();

`ifdef ALU_DIV_GUARD_EN
      setreq(0, DIV, 8'h10, 8'h00);
      bus.req_valid = 2'b01;
      step();
      bus.req_valid = '0;
      step();
      rsp_chk("div0", 16'hFFFF, 1'b0, 1'b1);
      step();
`endif

      setreq(0, DIV, 8'h10, 8'h03);
      bus.req_valid = 2'b01;
      step();
      bus.req_valid = '0;
      step();
      rsp_chk("div", 16'h0005, 1'b0, 1'b0);
      step();

      setreq(0, MIN, 8'h07, 8'h07);
      bus.req_valid = 2'b01;
      step();
      bus.req_valid = '0;
      step();
      rsp_chk("min_b", 16'h0007, 1'b0, 1'b0);
      step();

      // reset while requester 1's op is in EXEC
      setreq(1, ADD, 8'h01, 8'h01);
      bus.req_valid = 2'b10;
      #1;
      chk("ab_ready", 32'(bus.req_ready), 32'b10);
      step();
      rst_n = 1'b0;
      #1;
      chk("ab_valid", 32'(bus.rsp_valid), 0);
      chk("ab_data",  32'(bus.rsp_data),  0);
      chk("ab_id",    32'(bus.rsp_id),    0);
      chk("ab_dbz",   32'(bus.rsp_dbz),   0);
      chk("ab_rdy",   32'(bus.req_ready), 0);
      step();
      rst_n         = 1'b1;
      bus.req_valid = '0;
      step();
      chk("ab_noresp0", 32'(bus.rsp_valid), 0);
      step();
      chk("ab_noresp1", 32'(bus.rsp_valid), 0);

      setreq(0, OR, 8'h50, 8'h05);
      bus.req_valid = 2'b11;
      #1;
      chk("ab_ptr", 32'(bus.req_ready), 32'b01);
      step();
      bus.req_valid = 2'b10;
      step();
      rsp_chk("ab_or", 16'h0055, 1'b0, 1'b0);
      bus.req_valid = '0;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
